// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: shared state encoding and coordinate type for the frame scheduler
package frame_sched_pkg;
  localparam int COORD_W_DEF = 12;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef logic [COORD_W_DEF-1:0] coord_t;
endpackage

// File: rtl/frame_sched_fifo.sv
// frame_sched_fifo: first-word-fall-through FIFO, W bits x DEPTH entries, with fill count
// Ports: i_clk/i_rst (async active-high), i_push/i_data write side, i_pop/o_data/o_empty read
// side (o_data valid whenever !o_empty), o_count current occupancy.
module frame_sched_fifo
  import frame_sched_pkg::*;
#(
  parameter int W = 32,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge i_clk) if (i_push) r_mem[r_wp] <= i_data;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(i_push);
      r_rp <= r_rp + AW'(i_pop);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  // credit logic upstream must never push into a full FIFO unless a pop frees a slot
  always_ff @(posedge i_clk) if (!i_rst && i_push && !i_pop) assert (r_cnt != DEPTH_C);
  assign o_data = r_mem[r_rp];
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: raster-order shader request issue, credit-limited result FIFO, AXI4-Stream video out
// Ports: aclk/areset (async active-high); start/continuous/cfg_width/cfg_height control;
// busy/frame_done status; shd_req_* coordinate request handshake; shd_rsp_* in-order results;
// m_axis_* video master (tuser=SOF, tlast=EOL or EOF by LAST_PER_LINE).
// Optional FRAME_SCHEDULER_PERF_EN adds perf_frame_cycles / perf_stall_cycles.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int COORD_W = 12,
  parameter int PIX_W = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LAST_PER_LINE = 0
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               start,
  input  logic               continuous,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  output logic               busy,
  output logic               frame_done,
  output logic               shd_req_valid,
  input  logic               shd_req_ready,
  output logic [COORD_W-1:0] shd_req_x,
  output logic [COORD_W-1:0] shd_req_y,
  input  logic               shd_rsp_valid,
  input  logic [PIX_W-1:0]   shd_rsp_pixel,
  output logic [PIX_W-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast
`ifdef FRAME_SCHEDULER_PERF_EN
  ,
  output logic [31:0]        perf_frame_cycles,
  output logic [31:0]        perf_stall_cycles
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  state_t r_state, w_state_nxt;
  logic [COORD_W-1:0] r_w, r_h, r_x, r_y, r_ox, r_oy;
  logic [CW-1:0] r_out, w_count;
  logic [PIX_W-1:0] w_head;
  logic r_done, w_empty, w_push, w_pop, w_req_hs, w_start_ok, w_zero;
  logic w_last_x, w_last_req, w_eol, w_eof, w_frame_end;
  assign w_start_ok = start && r_state == IDLE;
  assign w_zero = cfg_width == '0 || cfg_height == '0;
  assign w_req_hs = shd_req_valid && shd_req_ready;
  assign w_last_x = r_x == r_w - 1'b1;
  assign w_last_req = w_last_x && r_y == r_h - 1'b1;
  assign w_eol = r_ox == r_w - 1'b1;
  assign w_eof = w_eol && r_oy == r_h - 1'b1;
  assign w_pop = m_axis_tvalid && m_axis_tready;
  assign w_frame_end = w_pop && w_eof;
  // r_out - w_count is the number of results still in flight; anything arriving
  // with nothing in flight (e.g. stale results after a reset) is discarded
  assign w_push = shd_rsp_valid && r_out != w_count;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = r_state == IDLE  ? (w_start_ok && !w_zero ? ISSUE : IDLE) :
                  r_state == ISSUE ? (w_req_hs && w_last_req ? DRAIN : ISSUE) :
                  (w_frame_end ? (continuous ? ISSUE : IDLE) : DRAIN);
    busy = r_state != IDLE;
    frame_done = r_done;
    shd_req_valid = r_state == ISSUE && r_out < DEPTH_C;
    shd_req_x = r_x;
    shd_req_y = r_y;
    m_axis_tvalid = !w_empty;
    m_axis_tdata = m_axis_tvalid ? w_head : '0;
    m_axis_tuser = m_axis_tvalid && r_ox == '0 && r_oy == '0;
    m_axis_tlast = m_axis_tvalid && w_eol && (LAST_PER_LINE != 0 || r_oy == r_h - 1'b1);
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_state <= IDLE;
      r_done <= 1'b0;
      r_w <= '0;
      r_h <= '0;
      r_x <= '0;
      r_y <= '0;
      r_ox <= '0;
      r_oy <= '0;
      r_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done <= w_frame_end || (w_start_ok && w_zero);
      if (w_start_ok) begin
        r_w <= cfg_width;
        r_h <= cfg_height;
      end
      if (w_start_ok || w_frame_end) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_req_hs) begin
        r_x <= w_last_x ? '0 : r_x + 1'b1;
        r_y <= w_last_x ? r_y + 1'b1 : r_y;
      end
      if (w_pop) begin
        r_ox <= w_eol ? '0 : r_ox + 1'b1;
        r_oy <= w_eof ? '0 : w_eol ? r_oy + 1'b1 : r_oy;
      end
      r_out <= r_out + CW'(w_req_hs) - CW'(w_pop);
    end
  frame_sched_fifo #(.W(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk(aclk),
    .i_rst(areset),
    .i_push(w_push),
    .i_data(shd_rsp_pixel),
    .i_pop(w_pop),
    .o_data(w_head),
    .o_empty(w_empty),
    .o_count(w_count)
  );
`ifdef FRAME_SCHEDULER_PERF_EN
  logic [31:0] r_pf, r_ps;
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_pf <= '0;
      r_ps <= '0;
    end else if (w_start_ok) begin
      r_pf <= '0;
      r_ps <= '0;
    end else begin
      if (busy && r_pf != '1) r_pf <= r_pf + 1'b1;
      if (m_axis_tvalid && !m_axis_tready && r_ps != '1) r_ps <= r_ps + 1'b1;
    end
  assign perf_frame_cycles = r_pf;
  assign perf_stall_cycles = r_ps;
`endif
endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed self-checking bench for frame_scheduler
module tb_frame_scheduler;
  logic aclk = 1'b0;
  logic areset, start, continuous, shd_req_ready, shd_rsp_valid, m_axis_tready;
  logic [11:0] cfg_width, cfg_height;
  logic [31:0] shd_rsp_pixel;
  logic busy, frame_done, shd_req_valid, m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic [11:0] shd_req_x, shd_req_y;
  logic [31:0] m_axis_tdata;
  logic busy_l, done_l, rv_l, tv_l, tu_l, tl_l;
  logic [11:0] rx_l, ry_l;
  logic [31:0] td_l;
  int total = 0, bad = 0;
  int lat = 1, rdy_pct = 100, n_cyc = 0, n_issued = 0, n_popped = 0;
  int got, tmo, fd_cnt, stall_bad, max_out;
  logic [31:0] b_data [256];
  logic b_user [256], b_last [256], b_last_l [256];
  typedef struct {logic [31:0] pix; int due;} rsp_t;
  rsp_t q[$];
  logic [23:0] req_log[$];

  frame_scheduler #(.COORD_W(12), .PIX_W(32), .FIFO_DEPTH(8), .LAST_PER_LINE(0)) dut (
    .aclk(aclk), .areset(areset), .start(start), .continuous(continuous),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .busy(busy), .frame_done(frame_done),
    .shd_req_valid(shd_req_valid), .shd_req_ready(shd_req_ready), .shd_req_x(shd_req_x),
    .shd_req_y(shd_req_y), .shd_rsp_valid(shd_rsp_valid), .shd_rsp_pixel(shd_rsp_pixel),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast));

  frame_scheduler #(.COORD_W(12), .PIX_W(32), .FIFO_DEPTH(8), .LAST_PER_LINE(1)) dut_l (
    .aclk(aclk), .areset(areset), .start(start), .continuous(continuous),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .busy(busy_l), .frame_done(done_l),
    .shd_req_valid(rv_l), .shd_req_ready(shd_req_ready), .shd_req_x(rx_l),
    .shd_req_y(ry_l), .shd_rsp_valid(shd_rsp_valid), .shd_rsp_pixel(shd_rsp_pixel),
    .m_axis_tdata(td_l), .m_axis_tvalid(tv_l), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(tu_l), .m_axis_tlast(tl_l));

  always #5 aclk = ~aclk;

  function automatic logic [31:0] pix(input int x, input int y);
    return {8'hA5, y[11:0], x[11:0]};
  endfunction

  // shader model: in-order results a fixed number of cycles after each accepted request
  always @(negedge aclk) begin
    n_cyc++;
    shd_req_ready = $urandom_range(99) < rdy_pct;
    shd_rsp_valid = 1'b0;
    if (q.size() > 0 && q[0].due <= n_cyc) begin
      shd_rsp_valid = 1'b1;
      shd_rsp_pixel = q[0].pix;
      void'(q.pop_front());
    end
    if (shd_req_valid && shd_req_ready) begin
      q.push_back('{pix(int'(shd_req_x), int'(shd_req_y)), n_cyc + lat});
      req_log.push_back({shd_req_y, shd_req_x});
      n_issued++;
    end
  end

  task automatic do_start(input int w, input int h);
    @(negedge aclk);
    cfg_width = 12'(w);
    cfg_height = 12'(h);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  // collects accepted beats, frame_done pulses, stall-stability violations and peak outstanding
  task automatic run_beats(input int nb, input int tr_pct, input int budget, input int post);
    logic pv, pu, pl;
    logic [31:0] pd;
    int cyc = 0, pc = 0;
    got = 0; fd_cnt = 0; stall_bad = 0; max_out = 0; pv = 0; pd = '0; pu = 0; pl = 0;
    while ((got < nb || pc < post) && cyc < budget) begin
      @(negedge aclk);
      cyc++;
      m_axis_tready = got < nb ? ($urandom_range(99) < tr_pct) : 1'b1;
      #1;
      if (got >= nb) pc++;
      fd_cnt += int'(frame_done);
      if (pv && {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast} !== {1'b1, pd, pu, pl}) stall_bad++;
      pv = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata; pu = m_axis_tuser; pl = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (got < 256) begin
          b_data[got] = m_axis_tdata; b_user[got] = m_axis_tuser;
          b_last[got] = m_axis_tlast; b_last_l[got] = tl_l;
        end
        got++;
        n_popped++;
      end
      if (n_issued - n_popped > max_out) max_out = n_issued - n_popped;
    end
    tmo = int'(got < nb);
  endtask

  task automatic test_reset();
    #3;
    total++; if ({busy, frame_done, shd_req_valid, m_axis_tvalid, m_axis_tuser, m_axis_tlast} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b want=000000", {busy, frame_done, shd_req_valid, m_axis_tvalid, m_axis_tuser, m_axis_tlast}); end
    total++; if ({shd_req_x, shd_req_y} !== 24'h0) begin bad++; $display("FAIL reset_xy got=%h want=0", {shd_req_x, shd_req_y}); end
    total++; if (m_axis_tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata got=%h want=0", m_axis_tdata); end
    @(negedge aclk); #2 areset = 1'b0;
  endtask

  task automatic test_zero();
    do_start(0, 5);
    #1;
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", frame_done); end
    total++; if ({busy, shd_req_valid} !== 2'b00) begin bad++; $display("FAIL zero_idle got=%b want=00", {busy, shd_req_valid}); end
    @(negedge aclk); #1;
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL zero_pulse got=%b want=0", frame_done); end
  endtask

  task automatic test_basic();
    lat = 1; rdy_pct = 100; req_log.delete();
    do_start(4, 2);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    run_beats(8, 100, 200, 3);
    total++; if (tmo !== 0 || got !== 8) begin bad++; $display("FAIL basic_beats got=%0d want=8", got); end
    for (int i = 0; i < 8; i++) begin
      total++; if (b_data[i] !== pix(i % 4, i / 4)) begin bad++; $display("FAIL basic_data[%0d] got=%h want=%h", i, b_data[i], pix(i % 4, i / 4)); end
      total++; if (b_user[i] !== (i == 0)) begin bad++; $display("FAIL basic_tuser[%0d] got=%b want=%b", i, b_user[i], i == 0); end
      total++; if (b_last[i] !== (i == 7)) begin bad++; $display("FAIL basic_tlast[%0d] got=%b want=%b", i, b_last[i], i == 7); end
    end
    total++; if (fd_cnt !== 1) begin bad++; $display("FAIL basic_done got=%0d want=1", fd_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", busy); end
    total++; if (req_log.size() !== 8) begin bad++; $display("FAIL basic_nreq got=%0d want=8", req_log.size()); end
    for (int i = 0; i < req_log.size() && i < 8; i++) begin
      total++; if (req_log[i] !== {12'(i / 4), 12'(i % 4)}) begin bad++; $display("FAIL basic_req[%0d] got=%h want=%h", i, req_log[i], {12'(i / 4), 12'(i % 4)}); end
    end
  endtask

  task automatic test_last_per_line();
    do_start(4, 2);
    run_beats(8, 100, 200, 3);
    total++; if (tmo !== 0) begin bad++; $display("FAIL lpl_beats got=%0d want=8", got); end
    for (int i = 0; i < 8; i++) begin
      total++; if (b_last_l[i] !== (i % 4 == 3)) begin bad++; $display("FAIL lpl_tlast[%0d] got=%b want=%b", i, b_last_l[i], i % 4 == 3); end
    end
  endtask

  task automatic test_latency();
    lat = 20; rdy_pct = 100; n_issued = 0; n_popped = 0;
    do_start(16, 4);
    run_beats(64, 100, 2000, 3);
    total++; if (tmo !== 0) begin bad++; $display("FAIL lat_beats got=%0d want=64", got); end
    for (int i = 0; i < 64; i++) begin
      total++; if (b_data[i] !== pix(i % 16, i / 16)) begin bad++; $display("FAIL lat_data[%0d] got=%h want=%h", i, b_data[i], pix(i % 16, i / 16)); end
    end
    total++; if (max_out !== 8) begin bad++; $display("FAIL lat_outstanding got=%0d want=8", max_out); end
    total++; if (fd_cnt !== 1) begin bad++; $display("FAIL lat_done got=%0d want=1", fd_cnt); end
  endtask

  task automatic test_stall();
    lat = 3; rdy_pct = 50;
    do_start(8, 8);
    run_beats(64, 50, 3000, 3);
    total++; if (tmo !== 0) begin bad++; $display("FAIL stall_beats got=%0d want=64", got); end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL stall_stable got=%0d want=0", stall_bad); end
    for (int i = 0; i < 64; i++) begin
      total++; if ({b_data[i], b_user[i], b_last[i]} !== {pix(i % 8, i / 8), i == 0, i == 63}) begin bad++; $display("FAIL stall_beat[%0d] got=%h/%b/%b want=%h/%b/%b", i, b_data[i], b_user[i], b_last[i], pix(i % 8, i / 8), i == 0, i == 63); end
    end
    rdy_pct = 100;
  endtask

  task automatic test_back_to_back();
    lat = 1; continuous = 1'b1;
    do_start(3, 3);
    run_beats(10, 100, 300, 0);
    continuous = 1'b0;
    total++; if (tmo !== 0) begin bad++; $display("FAIL b2b_beats1 got=%0d want=10", got); end
    total++; if ({b_last[8], b_user[8], b_user[9], b_last[9]} !== 4'b1010) begin bad++; $display("FAIL b2b_boundary got=%b want=1010", {b_last[8], b_user[8], b_user[9], b_last[9]}); end
    total++; if (b_data[9] !== pix(0, 0)) begin bad++; $display("FAIL b2b_first got=%h want=%h", b_data[9], pix(0, 0)); end
    total++; if (fd_cnt !== 1 || busy !== 1'b1) begin bad++; $display("FAIL b2b_mid done=%0d busy=%b want 1/1", fd_cnt, busy); end
    run_beats(8, 100, 300, 3);
    total++; if (tmo !== 0) begin bad++; $display("FAIL b2b_beats2 got=%0d want=8", got); end
    for (int i = 0; i < 8; i++) begin
      total++; if (b_data[i] !== pix((i + 1) % 3, (i + 1) / 3)) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, b_data[i], pix((i + 1) % 3, (i + 1) / 3)); end
    end
    total++; if (b_last[7] !== 1'b1 || fd_cnt !== 1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_end last=%b done=%0d busy=%b want 1/1/0", b_last[7], fd_cnt, busy); end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    lat = 4;
    do_start(8, 8);
    run_beats(5, 100, 200, 0);
    @(negedge aclk); #2 areset = 1'b1;
    #1;
    total++; if ({busy, frame_done, shd_req_valid, m_axis_tvalid, m_axis_tuser, m_axis_tlast} !== 6'b0) begin bad++; $display("FAIL arst_ctrl got=%b want=000000", {busy, frame_done, shd_req_valid, m_axis_tvalid, m_axis_tuser, m_axis_tlast}); end
    total++; if ({shd_req_x, shd_req_y, m_axis_tdata} !== 56'h0) begin bad++; $display("FAIL arst_data got=%h want=0", {shd_req_x, shd_req_y, m_axis_tdata}); end
    @(negedge aclk); @(negedge aclk); #2 areset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk); #1;
      if (m_axis_tvalid || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL arst_stale got=%0d want=0", seen); end
    lat = 1;
    do_start(2, 2);
    run_beats(4, 100, 200, 3);
    total++; if (tmo !== 0) begin bad++; $display("FAIL arst_beats got=%0d want=4", got); end
    for (int i = 0; i < 4; i++) begin
      total++; if ({b_data[i], b_user[i], b_last[i]} !== {pix(i % 2, i / 2), i == 0, i == 3}) begin bad++; $display("FAIL arst_beat[%0d] got=%h/%b/%b want=%h/%b/%b", i, b_data[i], b_user[i], b_last[i], pix(i % 2, i / 2), i == 0, i == 3); end
    end
    total++; if (fd_cnt !== 1) begin bad++; $display("FAIL arst_done got=%0d want=1", fd_cnt); end
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; continuous = 1'b0; cfg_width = '0; cfg_height = '0;
    m_axis_tready = 1'b0; shd_req_ready = 1'b0; shd_rsp_valid = 1'b0; shd_rsp_pixel = '0;
    test_reset();
    test_zero();
    test_basic();
    test_last_per_line();
    test_latency();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
